// File: rtl/chunked_add_pkg.sv
// Shared types and sizing helpers for the chunk-serial adder sequencer.
// Holds the FSM state encoding and the chunk-count / index-width arithmetic.
package chunked_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunked_add_seq_add_chunk.sv
// One CHUNK-bit adder slice with carry in and carry out.
// The sequencer reuses this single slice for every chunk of the operands.
module add_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/chunked_add_seq.sv
// Multi-cycle WIDTH-bit unsigned adder that walks the operands LSB chunk first
// through one CHUNK-bit slice, with valid/ready handshakes on both sides.
module chunked_add_seq
  import chunked_add_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             busy,
  output state_t           dbg_state
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = idx_w(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_width_check
    $error("chunked_add_seq: WIDTH must be a positive multiple of CHUNK");
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready depends only on state and out_ready, never on in_valid;
  // out_valid and out_sum hold steady until out_ready is seen.
  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [WIDTH:0]   sum_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic             c_chunk;
  logic             accept;
  logic             last_chunk;

  assign in_ready   = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
  assign accept     = in_valid & in_ready;
  assign last_chunk = (idx == LAST_IDX);

  assign a_chunk = a_q[idx*CHUNK +: CHUNK];
  assign b_chunk = b_q[idx*CHUNK +: CHUNK];

  add_chunk #(
    .CHUNK (CHUNK)
  ) u_add_chunk (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry),
    .s    (s_chunk),
    .cout (c_chunk)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry       <= 1'b0;
      idx         <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q    <= in_a;
            b_q    <= in_b;
            carry  <= 1'b0;
            idx    <= '0;
            state  <= ST_RUN;
            busy_q <= 1'b1;
          end
        end

        ST_RUN: begin
          sum_q[idx*CHUNK +: CHUNK] <= s_chunk;
          carry                     <= c_chunk;
          if (last_chunk) begin
            // idx parks on the last chunk rather than wrapping.
            sum_q[WIDTH] <= c_chunk;
            state        <= ST_DONE;
            out_valid_q  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              a_q   <= in_a;
              b_q   <= in_b;
              carry <= 1'b0;
              idx   <= '0;
              state <= ST_RUN;
            end else begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end
          end
        end

        default: begin
          state       <= ST_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign busy      = busy_q;
  assign dbg_state = state;

endmodule
